sram_block_initiator: RTL and testbench

SRAM_BLOCK_INITIATOR -- requirements
Module: sram_block_initiator

---
 rtl/sram_block_initiator.sv | 142 ++++++++++++++
 tb/tb_sram_block_initiator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_block_initiator.sv
// Walks a contiguous SRAM region, either writing a seed/increment pattern (FILL)
// or reading it back and counting mismatches against that pattern (CHECK).
module sram_block_initiator #(
  parameter int unsigned NumWords  = 32'd1024,
  parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 mode_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth:0]   len_i,
  input  logic [31:0]          seed_i,
  input  logic                 incr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          err_cnt_o,
  output logic [AddrWidth-1:0] first_err_addr_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [31:0]          sram_wdata_o,
  output logic [3:0]           sram_be_o,
  input  logic [31:0]          sram_rdata_i
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [AddrWidth:0]   LenOne  = 1;
  localparam logic [AddrWidth-1:0] AddrOne = 1;

  state_e               state_q;
  logic                 mode_q, incr_q;
  logic [AddrWidth:0]   len_q, idx_q;
  logic [31:0]          pat_q, pat_d;
  logic                 req_q, we_q;
  logic [AddrWidth-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           be_q;
  logic                 cmp_vld_q;
  logic [31:0]          exp_q;
  logic [AddrWidth-1:0] exp_addr_q;
  logic [15:0]          err_cnt_q;
  logic [AddrWidth-1:0] first_err_q;

  assign pat_d = incr_q ? pat_q + 32'd1 : pat_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      incr_q      <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      pat_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      cmp_vld_q   <= 1'b0;
      exp_q       <= '0;
      exp_addr_q  <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      cmp_vld_q <= 1'b0;
      // Read data for the previous cycle's request lands now; an abort discards it.
      if (cmp_vld_q && !abort_i && (sram_rdata_i != exp_q)) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        if (err_cnt_q == 16'd0)    first_err_q <= exp_addr_q;
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q      <= mode_i;
            incr_q      <= incr_i;
            len_q       <= len_i;
            idx_q       <= '0;
            pat_q       <= seed_i;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            if (len_i == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= RUN;
              req_q   <= 1'b1;
              we_q    <= ~mode_i;
              be_q    <= mode_i ? 4'h0 : 4'hF;
              addr_q  <= base_addr_i;
              wdata_q <= mode_i ? 32'd0 : seed_i;
            end
          end
        end
        RUN: begin
          if (abort_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
          end else begin
            if (mode_q) begin
              cmp_vld_q  <= 1'b1;
              exp_q      <= pat_q;
              exp_addr_q <= addr_q;
            end
            if (idx_q == len_q - LenOne) begin
              state_q <= mode_q ? DRAIN : DONE;
              req_q   <= 1'b0;
              we_q    <= 1'b0;
              be_q    <= '0;
              addr_q  <= '0;
              wdata_q <= '0;
            end else begin
              idx_q   <= idx_q + LenOne;
              addr_q  <= addr_q + AddrOne;
              pat_q   <= pat_d;
              wdata_q <= mode_q ? 32'd0 : pat_d;
            end
          end
        end
        DRAIN:   state_q <= abort_i ? IDLE : DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DONE);
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;
  assign sram_req_o       = req_q;
  assign sram_we_o        = we_q;
  assign sram_addr_o      = addr_q;
  assign sram_wdata_o     = wdata_q;
  assign sram_be_o        = be_q;

endmodule

// File: tb/tb_sram_block_initiator.sv
// Directed bench: 1024-word behavioural SRAM on the main instance, plus a 64K-word
// instance whose read data never matches, used to reach counter saturation.
module tb_sram_block_initiator;

  localparam int AW  = 10;
  localparam int AW2 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, mode = 1'b0, incr = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic [31:0]   seed = '0;
  logic          busy, done, req, we;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err, addr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    be;

  logic           start2 = 1'b0;
  logic [AW2:0]   len2 = '0;
  logic           busy2, done2, req2, we2;
  logic [15:0]    err_cnt2;
  logic [AW2-1:0] first_err2, addr2;
  logic [31:0]    wdata2;
  logic [3:0]     be2;
  logic [31:0]    rdata2 = 32'hFFFF_FFFF;

  sram_block_initiator dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .mode_i(mode),
    .base_addr_i(base), .len_i(len), .seed_i(seed), .incr_i(incr),
    .busy_o(busy), .done_o(done), .err_cnt_o(err_cnt), .first_err_addr_o(first_err),
    .sram_req_o(req), .sram_we_o(we), .sram_addr_o(addr), .sram_wdata_o(wdata),
    .sram_be_o(be), .sram_rdata_i(rdata));

  sram_block_initiator #(.NumWords(32'd65536)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .abort_i(1'b0), .mode_i(1'b1),
    .base_addr_i('0), .len_i(len2), .seed_i(32'd0), .incr_i(1'b0),
    .busy_o(busy2), .done_o(done2), .err_cnt_o(err_cnt2), .first_err_addr_o(first_err2),
    .sram_req_o(req2), .sram_we_o(we2), .sram_addr_o(addr2), .sram_wdata_o(wdata2),
    .sram_be_o(be2), .sram_rdata_i(rdata2));

  // Behavioural SRAM: read data valid exactly one cycle after the request.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (req && we) mem[addr] <= wdata;
    rdata <= (req && !we) ? mem[addr] : 32'h0BAD_F00D;
  end

  int req_cnt = 0, done_cnt = 0;
  always @(posedge clk) begin
    if (req)  req_cnt++;
    if (done) done_cnt++;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic m, input logic [AW-1:0] b, input logic [AW:0] l,
                           input logic [31:0] s, input logic inc);
    mode = m; base = b; len = l; seed = s; incr = inc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_req"}, req, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_be"}, be, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_wdata"}, wdata, 0);
  endtask

  initial begin
    int cyc, r0, d0;
    for (int k = 0; k < 1024; k++) mem[k] = 32'd0;

    // Reset
    repeat (3) @(negedge clk);
    chk_idle_outs("rst");
    chk("rst_err", err_cnt, 0);
    chk("rst_first", first_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // FILL base 10, len 4, seed 0x100, incr; a start pulse mid-run must be ignored
    start_cmd(1'b0, 10'd10, 11'd4, 32'h100, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("fill_req", req, 1);
      chk("fill_we", we, 1);
      chk("fill_be", be, 4'hF);
      chk("fill_addr", addr, 10 + k);
      chk("fill_wdata", wdata, 32'h100 + k);
      chk("fill_busy", busy, 1);
      chk("fill_done", done, 0);
      start = (k == 1);
      base  = (k == 1) ? 10'd500 : 10'd10;
      @(negedge clk);
    end
    start = 1'b0;
    chk("fill_done_t5", done, 1);
    chk("fill_req_t5", req, 0);
    @(negedge clk);
    chk_idle_outs("fill_after");

    // CHECK the same region, clean
    start_cmd(1'b1, 10'd10, 11'd4, 32'h100, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("chk_req", req, 1);
      chk("chk_we", we, 0);
      chk("chk_be", be, 0);
      chk("chk_wdata", wdata, 0);
      chk("chk_addr", addr, 10 + k);
      @(negedge clk);
    end
    chk("drain_busy", busy, 1);
    chk("drain_req", req, 0);
    chk("drain_done", done, 0);
    @(negedge clk);
    chk("chk_done_t6", done, 1);
    chk("chk_err0", err_cnt, 0);

    // CHECK with word 12 corrupted
    @(negedge clk);
    mem[12] = 32'hDEAD_BEEF;
    start_cmd(1'b1, 10'd10, 11'd4, 32'h100, 1'b1);
    wait_done(20, cyc);
    chk("corrupt_lat", cyc, 6);
    chk("corrupt_err", err_cnt, 1);
    chk("corrupt_first", first_err, 12);

    // Wrap-around, constant pattern
    @(negedge clk);
    start_cmd(1'b0, 10'd1022, 11'd4, 32'hA5A5_5A5A, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_addr", addr, (1022 + k) % 1024);
      chk("wrap_wdata", wdata, 32'hA5A5_5A5A);
      @(negedge clk);
    end
    chk("wrap_done", done, 1);

    // len = 0
    @(negedge clk);
    r0 = req_cnt;
    start_cmd(1'b0, 10'd5, 11'd0, 32'h1, 1'b1);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 1);
    chk("len0_req", req, 0);
    @(negedge clk);
    chk("len0_busy_after", busy, 0);
    chk("len0_reqs", req_cnt - r0, 0);

    // Abort in 2nd RUN cycle of len 8, with a simultaneous start (len 0) that must lose
    r0 = req_cnt; d0 = done_cnt;
    start_cmd(1'b0, 10'd100, 11'd8, 32'h7, 1'b1);
    chk("abort_addr1", addr, 100);
    @(negedge clk);
    chk("abort_addr2", addr, 101);
    abort = 1'b1; start = 1'b1; len = 11'd0;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_req", req, 0);
    repeat (3) @(negedge clk);
    chk("abort_busy_later", busy, 0);
    chk("abort_reqs", req_cnt - r0, 2);
    chk("abort_no_done", done_cnt - d0, 0);

    // CHECK len 1024 against all-corrupt memory
    for (int k = 0; k < 1024; k++) mem[k] = ~k;
    start_cmd(1'b1, 10'd0, 11'd1024, 32'd0, 1'b1);
    wait_done(1200, cyc);
    chk("full_lat", cyc, 1026);
    chk("full_err", err_cnt, 1024);
    chk("full_first", first_err, 0);

    // Abort during CHECK keeps counters and drops the in-flight compare
    @(negedge clk);
    start_cmd(1'b1, 10'd0, 11'd8, 32'd0, 1'b1);
    repeat (3) @(negedge clk);
    chk("cabort_err_pre", err_cnt, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("cabort_err", err_cnt, 2);
    chk("cabort_busy", busy, 0);

    // Reset mid-RUN
    @(negedge clk);
    d0 = done_cnt;
    start_cmd(1'b1, 10'd0, 11'd8, 32'd0, 1'b1);
    repeat (3) @(negedge clk);
    chk("rstrun_err_pre", err_cnt, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle_outs("rstrun");
    chk("rstrun_err", err_cnt, 0);
    chk("rstrun_first", first_err, 0);
    @(negedge clk);
    chk("rstrun_req_after", req, 0);
    chk("rstrun_no_done", done_cnt - d0, 0);

    // Saturation: 65536 mismatching reads on the 64K-word instance
    len2 = 17'h10000; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    while (done2 !== 1'b1 && cyc < 66000) begin
      @(negedge clk);
      cyc++;
    end
    chk("sat_lat", cyc, 65538);
    chk("sat_err", err_cnt2, 16'hFFFF);
    chk("sat_first", first_err2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
